// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and the SPI slave/RAM subsystem:
// command encodings, frame width and the frame FSM state set.
package spi_pkg;

  localparam int FRAME_W = 10;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_SHIFT,
    ST_TURN,
    ST_CAPTURE,
    ST_END
  } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Frame datapath: parallel-in/serial-out transmit register, serial-in capture
// register and a shared down-counter used for shift, turnaround and capture.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int W     = FRAME_W,
  parameter int CAP_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             shift,
  input  logic             cap_en,
  input  logic             cap_bit,
  input  logic             cnt_ld,
  input  logic [CNT_W-1:0] cnt_val,
  input  logic             cnt_dec,
  output logic             sout,
  output logic             sout_nx,
  output logic [CNT_W-1:0] cnt,
  output logic [CAP_W-1:0] cap_nx
);

  logic [W-1:0]     sr;
  logic [CAP_W-1:0] cap;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cap <= '0;
      cnt <= '0;
    end else begin
      if (load)        sr <= load_data;
      else if (shift)  sr <= {sr[W-2:0], 1'b0};
      if (cap_en)      cap <= cap_nx;
      if (cnt_ld)      cnt <= cnt_val;
      else if (cnt_dec) cnt <= cnt - CNT_W'(1);
    end
  end

  // sout_nx is the bit that reaches the MSB after the next shift, so the
  // registered MOSI can be loaded one cycle ahead of the shift itself.
  assign sout    = sr[W-1];
  assign sout_nx = sr[W-2];
  assign cap_nx  = {cap[CAP_W-2:0], cap_bit};

endmodule

// File: rtl/spi_master_ctrl.sv
// Host-side SPI master: turns single-beat commands into 11-bit MOSI frames
// (path bit + type + payload) and returns captured MISO read data.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_TURN = 2,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_type,
  input  logic [ADDR_W-1:0] cmd_payload,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int FW      = ADDR_W + 2;
  localparam int CNT_MAX = (FW > RD_TURN) ? FW : RD_TURN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  spi_state_e        state, state_nx;
  logic [1:0]        cur_type;
  logic              rd_addr_loaded;
  logic              err_q;
  logic              accept;
  logic              is_rd_data;

  logic              ss_nx, mosi_nx, rsp_fire;
  logic              load, shift, cap_en, cnt_ld, cnt_dec;
  logic [CNT_W-1:0]  cnt_val, cnt;
  logic              sout, sout_nx;
  logic [ADDR_W-1:0] cap_nx;
  logic [FW-1:0]     frame;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = ~cmd_ready;
  assign accept     = cmd_ready && cmd_valid;
  assign is_rd_data = (cur_type == CMD_RD_DATA);
  // The payload is meaningless for RD_DATA; zeros go on the wire instead.
  assign frame      = {cmd_type, (cmd_type == CMD_RD_DATA) ? {ADDR_W{1'b0}} : cmd_payload};

  spi_shift_reg #(.W(FW), .CAP_W(ADDR_W), .CNT_W(CNT_W)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (frame),
    .shift     (shift),
    .cap_en    (cap_en),
    .cap_bit   (MISO),
    .cnt_ld    (cnt_ld),
    .cnt_val   (cnt_val),
    .cnt_dec   (cnt_dec),
    .sout      (sout),
    .sout_nx   (sout_nx),
    .cnt       (cnt),
    .cap_nx    (cap_nx)
  );

  // Outputs are computed for the upcoming state and registered, so SS_n/MOSI
  // are glitch-free flops aligned with the state they belong to.
  always_comb begin
    state_nx = state;
    ss_nx    = 1'b1;
    mosi_nx  = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    cap_en   = 1'b0;
    cnt_ld   = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    rsp_fire = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nx = ST_SEL;
          load     = 1'b1;
          cnt_ld   = 1'b1;
          cnt_val  = CNT_W'(FW - 1);
          ss_nx    = 1'b0;
          mosi_nx  = cmd_type[1];
        end
      end
      ST_SEL: begin
        state_nx = ST_SHIFT;
        ss_nx    = 1'b0;
        mosi_nx  = sout;
      end
      ST_SHIFT: begin
        ss_nx = 1'b0;
        if (cnt == '0) begin
          if (!is_rd_data) begin
            state_nx = ST_END;
            ss_nx    = 1'b1;
          end else if (RD_TURN > 0) begin
            state_nx = ST_TURN;
            cnt_ld   = 1'b1;
            cnt_val  = CNT_W'(RD_TURN - 1);
          end else begin
            state_nx = ST_CAPTURE;
            cnt_ld   = 1'b1;
            cnt_val  = CNT_W'(ADDR_W - 1);
          end
        end else begin
          shift   = 1'b1;
          cnt_dec = 1'b1;
          mosi_nx = sout_nx;
        end
      end
      ST_TURN: begin
        ss_nx = 1'b0;
        if (cnt == '0) begin
          state_nx = ST_CAPTURE;
          cnt_ld   = 1'b1;
          cnt_val  = CNT_W'(ADDR_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        cap_en = 1'b1;
        if (cnt == '0) begin
          state_nx = ST_END;
          rsp_fire = 1'b1;
        end else begin
          ss_nx   = 1'b0;
          cnt_dec = 1'b1;
        end
      end
      ST_END: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      SS_n           <= 1'b1;
      MOSI           <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      rd_addr_loaded <= 1'b0;
      cur_type       <= CMD_WR_ADDR;
      err_q          <= 1'b0;
    end else begin
      state     <= state_nx;
      SS_n      <= ss_nx;
      MOSI      <= mosi_nx;
      rsp_valid <= rsp_fire;
      if (rsp_fire) begin
        rsp_data <= cap_nx;
        rsp_err  <= err_q;
      end
      if (accept) begin
        cur_type <= cmd_type;
        err_q    <= ~rd_addr_loaded;
      end
      // The address flag only changes on a completed frame, never an aborted one.
      if (state == ST_END) begin
        if (cur_type == CMD_RD_ADDR)      rd_addr_loaded <= 1'b1;
        else if (cur_type == CMD_RD_DATA) rd_addr_loaded <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl: stimulus pushes expected frames and
// responses; negedge monitors pop and compare; a behavioural slave drives MISO.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int RD_TURN = 2;
  localparam int RD_LAT  = 22;   // acceptance cycle to rsp_valid cycle
  localparam int WR_IDLE = 13;   // acceptance to cmd_ready, non-RD_DATA
  localparam int RD_IDLE = 23;   // acceptance to cmd_ready, RD_DATA

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_type = 2'b00;
  logic [7:0] cmd_payload = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b1;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_TURN(RD_TURN), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_payload(cmd_payload), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .SS_n(SS_n),
    .MOSI(MOSI), .MISO(MISO)
  );

  typedef struct { logic [10:0] bits; int len; } frm_t;
  typedef struct { logic [7:0] data; logic err; int at; } rsp_t;

  frm_t       frm_q[$];
  rsp_t       rsp_q[$];
  frm_t       fe;
  rsp_t       re;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         rsp_cnt = 0;
  int         last_acc = 0;
  logic [7:0] slave_byte = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave: after SS_n falls, cycles RD_TURN+11 .. RD_TURN+18 of the frame carry
  // slave_byte MSB first; MISO is driven high elsewhere to expose stray sampling.
  int sidx = 0;
  always @(negedge clk) begin
    if (rst || SS_n) begin
      sidx = 0;
      MISO = 1'b1;
    end else begin
      if (sidx >= 11 + RD_TURN && sidx < 19 + RD_TURN) MISO = slave_byte[18 + RD_TURN - sidx];
      else MISO = 1'b1;
      sidx++;
    end
  end

  // Frame monitor: first 11 MOSI bits and SS_n low length per frame.
  int          flen = 0;
  logic [10:0] fbits = '0;
  always @(negedge clk) begin
    if (rst) begin
      flen = 0;
      fbits = '0;
    end else if (!SS_n) begin
      if (flen < 11) fbits = {fbits[9:0], MOSI};
      flen++;
    end else if (flen > 0) begin
      if (frm_q.size() == 0) chk("frame_unexpected", 32'(flen), 32'd0);
      else begin
        fe = frm_q.pop_front();
        chk("frame_bits", 32'(fbits), 32'(fe.bits));
        chk("frame_len", 32'(flen), 32'(fe.len));
      end
      flen = 0;
      fbits = '0;
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      rsp_cnt++;
      if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      else begin
        re = rsp_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(re.data));
        chk("rsp_err", 32'(rsp_err), 32'(re.err));
        chk("rsp_cycle", 32'(cyc), 32'(re.at));
      end
    end
  end

  // Called just after a negedge; returns at the negedge of cycle T+1.
  task automatic send(input logic [1:0] t, input logic [7:0] p, input logic [10:0] exp_bits,
                      input logic exp_err, input bit push, input bit keep);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_type = t;
    cmd_payload = p;
    while (!cmd_ready) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        chk("ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        return;
      end
    end
    last_acc = cyc;
    if (push) begin
      frm_q.push_back('{bits: exp_bits, len: (t == CMD_RD_DATA) ? 19 + RD_TURN : 11});
      if (t == CMD_RD_DATA) rsp_q.push_back('{data: slave_byte, err: exp_err, at: cyc + RD_LAT});
    end
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_cyc);
    int n;
    n = 0;
    while (busy && n <= 60) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_ss_n", 32'(SS_n), 32'd1);
      chk("rst_mosi", 32'(MOSI), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // RD_DATA with no RD_ADDR since reset, twice: both flag an error.
    slave_byte = 8'h5A;
    send(CMD_RD_DATA, 8'hFF, 11'b1_11_00000000, 1'b1, 1'b1, 1'b0);
    wait_idle("rd_noaddr_idle", last_acc + RD_IDLE);
    slave_byte = 8'hC3;
    send(CMD_RD_DATA, 8'h00, 11'b1_11_00000000, 1'b1, 1'b1, 1'b0);
    wait_idle("rd_noaddr2_idle", last_acc + RD_IDLE);

    // RD_ADDR 0x3C then RD_DATA returning 0xA5.
    send(CMD_RD_ADDR, 8'h3C, 11'b1_10_00111100, 1'b0, 1'b1, 1'b0);
    wait_idle("rdaddr_idle", last_acc + WR_IDLE);
    slave_byte = 8'hA5;
    send(CMD_RD_DATA, 8'h00, 11'b1_11_00000000, 1'b0, 1'b1, 1'b0);
    wait_idle("rd_idle", last_acc + RD_IDLE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rsp_hold_data", 32'(rsp_data), 32'h0000_00A5);
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd0);
    end

    // WR_ADDR 0x3C: SS_n falls at T+1 carrying path bit 0.
    send(CMD_WR_ADDR, 8'h3C, 11'b0_00_00111100, 1'b0, 1'b1, 1'b0);
    chk("wr_t1_ss_n", 32'(SS_n), 32'd0);
    chk("wr_t1_mosi", 32'(MOSI), 32'd0);
    wait_idle("wr_idle", last_acc + WR_IDLE);

    // cmd_valid held high across four mixed commands.
    send(CMD_WR_ADDR, 8'h12, 11'b0_00_00010010, 1'b0, 1'b1, 1'b1);
    a = last_acc;
    send(CMD_WR_DATA, 8'h34, 11'b0_01_00110100, 1'b0, 1'b1, 1'b1);
    chk("held_gap1", 32'(last_acc - a), 32'(WR_IDLE));
    a = last_acc;
    send(CMD_RD_ADDR, 8'h12, 11'b1_10_00010010, 1'b0, 1'b1, 1'b1);
    chk("held_gap2", 32'(last_acc - a), 32'(WR_IDLE));
    a = last_acc;
    slave_byte = 8'h69;
    send(CMD_RD_DATA, 8'hFF, 11'b1_11_00000000, 1'b0, 1'b1, 1'b0);
    chk("held_gap3", 32'(last_acc - a), 32'(WR_IDLE));
    wait_idle("held_idle", last_acc + RD_IDLE);
    chk("rsp_count_pre", 32'(rsp_cnt), 32'd4);

    // Reset during T+6 of an RD_DATA frame.
    slave_byte = 8'hFF;
    send(CMD_RD_DATA, 8'h00, 11'b1_11_00000000, 1'b1, 1'b0, 1'b0);
    a = last_acc;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cyc != a + 6 && n < 30);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ss_n", 32'(SS_n), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_data", 32'(rsp_data), 32'd0);
    repeat (25) @(negedge clk);
    chk("rsp_count_abort", 32'(rsp_cnt), 32'd4);

    send(CMD_RD_ADDR, 8'h81, 11'b1_10_10000001, 1'b0, 1'b1, 1'b0);
    wait_idle("post_rdaddr_idle", last_acc + WR_IDLE);
    slave_byte = 8'h3E;
    send(CMD_RD_DATA, 8'h00, 11'b1_11_00000000, 1'b0, 1'b1, 1'b0);
    wait_idle("post_rd_idle", last_acc + RD_IDLE);

    repeat (5) @(negedge clk);
    chk("rsp_count_final", 32'(rsp_cnt), 32'd5);
    chk("frame_q_empty", 32'(frm_q.size()), 32'd0);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
